// File: rtl/ctr_pkg.sv
// Shared types for the decade interval-timer scheduler.
// Holds the FSM state encoding and the terminal count of the mod-10 counter.
package ctr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] DEC_MAX = 4'd9;

endpackage

// File: rtl/decade_cnt.sv
// Mod-10 counter with enable and synchronous clear.
// cout flags the terminal count while counting is enabled.
module decade_cnt
   import ctr_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] cnt,
   output logic       cout
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= 4'd0;
      end else if (clr) begin
         cnt <= 4'd0;
      end else if (en) begin
         cnt <= (cnt == DEC_MAX) ? 4'd0 : cnt + 4'd1;
      end
   end

   assign cout = en && (cnt == DEC_MAX);

endmodule

// File: rtl/decade_timer_sched.sv
// Round-robin scheduler lending one decade counter to NREQ requesters as an
// interval timer of len[i]*10 cycles.
//
//   state | meaning
//   IDLE  | arbitration cycle; winner's len latched into rem
//   RUN   | counter owned by grant; rem counts remaining decade periods
//   DONE  | one-cycle done pulse; pointer moves past the finished requester
module decade_timer_sched
   import ctr_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int LEN_W = 8
)
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN_W-1:0] len,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic [3:0]            cnt,
   output logic                  cout,
   output logic [NREQ-1:0]       done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t             state;
   logic [IW-1:0]      gidx;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      win;
   logic [IW-1:0]      gidx_nxt;
   logic [LEN_W-1:0]   rem;
   logic [LEN_W-1:0]   len_win;
   logic               run;
   logic               abort;

   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IW-1:0]   p);
      logic [IW-1:0] w;
      logic          found;
      int            idx;
      w     = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(p) + k) % NREQ;
         if (!found && r[idx]) begin
            w     = IW'(idx);
            found = 1'b1;
         end
      end
      return w;
   endfunction

   assign win      = rr_pick(req, ptr);
   assign len_win  = len[int'(win)*LEN_W +: LEN_W];
   assign gidx_nxt = (int'(gidx) == NREQ-1) ? '0 : gidx + IW'(1);
   assign run      = (state == RUN);
   // Dropping the owner's request abandons the interval; the counter restarts from zero.
   assign abort    = run && !req[gidx];

   decade_cnt u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .en   (run),
      .clr  (abort),
      .cnt  (cnt),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         grant <= '0;
         busy  <= 1'b0;
         done  <= '0;
         gidx  <= '0;
         ptr   <= '0;
         rem   <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gidx <= win;
                  rem  <= len_win;
                  busy <= 1'b1;
                  if (len_win != '0) begin
                     state <= RUN;
                     grant <= NREQ'(1) << win;
                  end else begin
                     state <= DONE;
                     done  <= NREQ'(1) << win;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  ptr   <= gidx_nxt;
               end else if (cnt == DEC_MAX && rem != '0) begin
                  rem <= rem - LEN_W'(1);
                  if (rem == LEN_W'(1)) begin
                     state       <= DONE;
                     grant       <= '0;
                     done[gidx]  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               ptr   <= gidx_nxt;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decade_timer_sched.sv
// Directed self-checking bench for decade_timer_sched (NREQ=4, LEN_W=8).
// Cycle k is the interval following the k-th rising edge after stimulus is applied.
module tb_decade_timer_sched;

   localparam int NREQ  = 4;
   localparam int LEN_W = 8;

   logic                  clk;
   logic                  rstn;
   logic [NREQ-1:0]       req;
   logic [NREQ*LEN_W-1:0] len;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [3:0]            cnt;
   logic                  cout;
   logic [NREQ-1:0]       done;

   int checks = 0;
   int errors = 0;

   decade_timer_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .req   (req),
      .len   (len),
      .grant (grant),
      .busy  (busy),
      .cnt   (cnt),
      .cout  (cout),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      req  = '0;
      len  = '0;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   task automatic set_len(input int i, input logic [LEN_W-1:0] v);
      len[i*LEN_W +: LEN_W] = v;
   endtask

   initial begin
      rstn = 1'b0;
      req  = '0;
      len  = '0;
      do_reset();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_cnt",   32'(cnt),   32'h0);
      chk("rst_cout",  32'(cout),  32'h0);
      chk("rst_done",  32'(done),  32'h0);

      // 1: single requester, two decade periods
      set_len(0, 8'd2);
      req = 4'b0001;
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk("t1_grant", 32'(grant), 32'h1);
         chk("t1_cnt",   32'(cnt),   32'((c - 1) % 10));
         chk("t1_cout",  32'(cout),  32'((c == 10) || (c == 20)));
         chk("t1_done",  32'(done),  32'h0);
      end
      tick();
      chk("t1_done21",  32'(done),  32'h1);
      chk("t1_grant21", 32'(grant), 32'h0);
      chk("t1_busy21",  32'(busy),  32'h1);
      chk("t1_cnt21",   32'(cnt),   32'h0);
      req = '0;
      tick();
      chk("t1_done22", 32'(done), 32'h0);
      chk("t1_busy22", 32'(busy), 32'h0);

      // 2: simultaneous requests 0 and 2 from pointer 0
      do_reset();
      set_len(0, 8'd1);
      set_len(2, 8'd1);
      req = 4'b0101;
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk("t2_grant0", 32'(grant), 32'h1);
      end
      chk("t2_cout10", 32'(cout), 32'h1);
      tick();
      chk("t2_done0", 32'(done), 32'h1);
      req = 4'b0100;
      tick();
      chk("t2_idle_grant", 32'(grant), 32'h0);
      chk("t2_idle_busy",  32'(busy),  32'h0);
      for (int c = 13; c <= 22; c++) begin
         tick();
         chk("t2_grant2", 32'(grant), 32'h4);
      end
      tick();
      chk("t2_done2", 32'(done), 32'h4);
      req = '0;
      tick();

      // 3: all four held, order 0,1,2,3,0
      do_reset();
      len = {8'd1, 8'd1, 8'd1, 8'd1};
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("t3_grant_start", 32'(grant), 32'(1 << (j % 4)));
         chk("t3_cnt_start",   32'(cnt),   32'h0);
         repeat (9) tick();
         chk("t3_grant_end", 32'(grant), 32'(1 << (j % 4)));
         chk("t3_cout_end",  32'(cout),  32'h1);
         tick();
         chk("t3_done",       32'(done),  32'(1 << (j % 4)));
         chk("t3_done_grant", 32'(grant), 32'h0);
         tick();
         chk("t3_idle_grant", 32'(grant), 32'h0);
         chk("t3_idle_busy",  32'(busy),  32'h0);
         if (j == 4) req = '0;
      end
      tick();
      chk("t3_quiet_grant", 32'(grant), 32'h0);

      // 4: zero-length request goes straight to DONE without a grant
      do_reset();
      set_len(1, 8'd0);
      req = 4'b0010;
      tick();
      chk("t4_done",  32'(done),  32'h2);
      chk("t4_grant", 32'(grant), 32'h0);
      chk("t4_cnt",   32'(cnt),   32'h0);
      chk("t4_busy",  32'(busy),  32'h1);
      req = '0;
      tick();
      chk("t4_done_clr", 32'(done), 32'h0);
      chk("t4_cnt2",     32'(cnt),  32'h0);

      // 5: abort of requester 0 at RUN cycle 5; pointer then favours 1
      do_reset();
      set_len(0, 8'd3);
      set_len(1, 8'd1);
      req = 4'b0011;
      repeat (5) tick();
      chk("t5_grant5", 32'(grant), 32'h1);
      chk("t5_cnt5",   32'(cnt),   32'h4);
      req = 4'b0010;
      tick();
      chk("t5_abort_grant", 32'(grant), 32'h0);
      chk("t5_abort_cnt",   32'(cnt),   32'h0);
      chk("t5_abort_done",  32'(done),  32'h0);
      chk("t5_abort_busy",  32'(busy),  32'h0);
      req = 4'b0011;
      tick();
      chk("t5_next_grant", 32'(grant), 32'h2);
      repeat (9) tick();
      chk("t5_grant1_end", 32'(grant), 32'h2);
      tick();
      chk("t5_done1", 32'(done), 32'h2);
      req = '0;
      tick();

      // 6: asynchronous reset in the middle of a RUN interval
      do_reset();
      set_len(0, 8'd5);
      req = 4'b0001;
      repeat (7) tick();
      chk("t6_cnt7",   32'(cnt),   32'h6);
      chk("t6_grant7", 32'(grant), 32'h1);
      rstn = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(grant), 32'h0);
      chk("t6_rst_busy",  32'(busy),  32'h0);
      chk("t6_rst_cnt",   32'(cnt),   32'h0);
      chk("t6_rst_cout",  32'(cout),  32'h0);
      chk("t6_rst_done",  32'(done),  32'h0);
      req = '0;
      @(negedge clk);
      rstn = 1'b1;
      set_len(1, 8'd1);
      req = 4'b0011;
      tick();
      chk("t6_post_grant", 32'(grant), 32'h1);
      chk("t6_post_done",  32'(done),  32'h0);
      req = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
